// File: rtl/br_flow_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module   : br_flow_pattern_pkg
// Brief    : Shared state encoding for the flow pattern source.
// Revision : 1.0 - initial release
// ============================================================================
package br_flow_pattern_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/br_flow_pattern_gap_ctr.sv
`default_nettype none
// ============================================================================
// Module   : br_flow_pattern_gap_ctr
// Brief    : Loadable down-counter; expire flags the last idle gap cycle.
// Revision : 1.0 - initial release
// ============================================================================
module br_flow_pattern_gap_ctr #(
  parameter int GapWidth = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [GapWidth-1:0] load_val,
  input  logic                en,
  output logic                expire
);

  localparam logic [GapWidth-1:0] C_ONE = GapWidth'(1);

  logic [GapWidth-1:0] count_q;
  logic [GapWidth-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - C_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Seeing 1 means this is the final gap cycle, so SEND follows next
  assign expire = (count_q == C_ONE);

endmodule
`default_nettype wire

// File: rtl/br_flow_pattern_src.sv
`default_nettype none
// ============================================================================
// Module   : br_flow_pattern_src
// Brief    : Burst source of incrementing data with gaps, backpressure, abort.
// Revision : 1.0 - initial release
// ============================================================================
module br_flow_pattern_src
  import br_flow_pattern_pkg::*;
#(
  parameter int Width      = 8,
  parameter int CountWidth = 16,
  parameter int GapWidth   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [Width-1:0]      start_value,
  input  logic [CountWidth-1:0] num_items,
  input  logic [GapWidth-1:0]   gap_cycles,
  input  logic                  abort,
  input  logic                  ready,
  output logic                  valid,
  output logic [Width-1:0]      data,
  output logic                  busy,
  output logic                  done,
  output logic [CountWidth-1:0] sent_count
);

  if (Width < 1) begin : g_chk_width
    $error("Width must be >= 1");
  end
  if (CountWidth < 1) begin : g_chk_count_width
    $error("CountWidth must be >= 1");
  end
  if (GapWidth < 1) begin : g_chk_gap_width
    $error("GapWidth must be >= 1");
  end

  localparam logic [Width-1:0]      C_DATA_ONE = Width'(1);
  localparam logic [CountWidth-1:0] C_CNT_ONE  = CountWidth'(1);

  state_e                state_q,      state_d;
  logic                  valid_q,      valid_d;
  logic [Width-1:0]      data_q,       data_d;
  logic                  busy_q,       busy_d;
  logic                  done_q,       done_d;
  logic [CountWidth-1:0] sent_count_q, sent_count_d;
  logic [CountWidth-1:0] num_items_q,  num_items_d;
  logic [GapWidth-1:0]   gap_cycles_q, gap_cycles_d;
  logic                  abort_q,      abort_d;

  logic                  w_xfer;
  logic [CountWidth-1:0] w_sent_inc;
  logic                  w_gap_load;
  logic                  w_gap_en;
  logic                  w_gap_expire;

  br_flow_pattern_gap_ctr #(
    .GapWidth (GapWidth)
  ) u_gap_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_gap_load),
    .load_val (gap_cycles_q),
    .en       (w_gap_en),
    .expire   (w_gap_expire)
  );

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    data_d       = data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    sent_count_d = sent_count_q;
    num_items_d  = num_items_q;
    gap_cycles_d = gap_cycles_q;
    abort_d      = abort_q;
    w_gap_load   = 1'b0;
    w_gap_en     = 1'b0;
    w_xfer       = valid_q && ready;
    w_sent_inc   = sent_count_q + C_CNT_ONE;

    case (state_q)
      IDLE: begin
        if (start) begin
          abort_d      = 1'b0;
          num_items_d  = num_items;
          gap_cycles_d = gap_cycles;
          sent_count_d = '0;
          if (num_items != '0) begin
            state_d = SEND;
            valid_d = 1'b1;
            data_d  = start_value;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      SEND: begin
        if (w_xfer) begin
          sent_count_d = w_sent_inc;
          // A pending or coincident abort turns this transfer into the last one
          if ((w_sent_inc == num_items_q) || abort_q || abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            abort_d = 1'b0;
          end else begin
            data_d = data_q + C_DATA_ONE;
            if (gap_cycles_q != '0) begin
              state_d    = GAP;
              valid_d    = 1'b0;
              w_gap_load = 1'b1;
            end
          end
        end else if (abort) begin
          abort_d = 1'b1;
        end
      end

      GAP: begin
        w_gap_en = 1'b1;
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (w_gap_expire) begin
          state_d = SEND;
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sent_count_q <= '0;
      num_items_q  <= '0;
      gap_cycles_q <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sent_count_q <= sent_count_d;
      num_items_q  <= num_items_d;
      gap_cycles_q <= gap_cycles_d;
      abort_q      <= abort_d;
    end
  end

  assign valid      = valid_q;
  assign data       = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sent_count = sent_count_q;

  a_hold_under_backpressure: assert property (@(posedge clk) disable iff (!rst_n)
    (valid_q && !ready) |=> (valid_q && $stable(data_q)));

  a_done_valid_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(done_q && valid_q));

  a_valid_needs_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !busy_q |-> !valid_q);

endmodule
`default_nettype wire

// File: tb/tb_br_flow_pattern_src.sv
`default_nettype none
// ============================================================================
// Module   : tb_br_flow_pattern_src
// Brief    : Scoreboard bench for br_flow_pattern_src with directed bursts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_br_flow_pattern_src;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  start_value;
  logic [15:0] num_items;
  logic [3:0]  gap_cycles;
  logic        abort;
  logic        ready;
  logic        valid;
  logic [7:0]  data;
  logic        busy;
  logic        done;
  logic [15:0] sent_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  exp_data[$];
  logic [15:0] exp_done[$];

  br_flow_pattern_src #(
    .Width      (8),
    .CountWidth (16),
    .GapWidth   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_value (start_value),
    .num_items   (num_items),
    .gap_cycles  (gap_cycles),
    .abort       (abort),
    .ready       (ready),
    .valid       (valid),
    .data        (data),
    .busy        (busy),
    .done        (done),
    .sent_count  (sent_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_items(input logic [7:0] sv, input int n);
    logic [7:0] v;
    v = sv;
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(v);
      v = v + 8'd1;
    end
  endtask

  task automatic start_burst(input logic [7:0] sv, input logic [15:0] n, input logic [3:0] g);
    start       = 1'b1;
    start_value = sv;
    num_items   = n;
    gap_cycles  = g;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic expect_seq(input int len, input logic [31:0] vseq, input logic [31:0] dseq);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      chk("pattern_valid", {31'd0, valid}, {31'd0, vseq[i]});
      chk("pattern_done", {31'd0, done}, {31'd0, dseq[i]});
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_within_budget", {31'd0, seen}, 32'd1);
  endtask

  // Scoreboard monitor: every handshake and every done pulse consumes an expectation
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (valid && ready) begin
          chk("xfer_expected", {31'd0, exp_data.size() != 0}, 32'd1);
          if (exp_data.size() != 0) chk("xfer_data", {24'd0, data}, {24'd0, exp_data.pop_front()});
        end
        if (done) begin
          chk("done_expected", {31'd0, exp_done.size() != 0}, 32'd1);
          if (exp_done.size() != 0) chk("done_sent_count", {16'd0, sent_count}, {16'd0, exp_done.pop_front()});
          chk("done_valid_low", {31'd0, valid}, 32'd0);
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    start_value = '0;
    num_items   = '0;
    gap_cycles  = '0;
    abort       = 1'b0;
    ready       = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sent_count", {16'd0, sent_count}, 32'd0);

    // Back-to-back with data wrap; start issued right as reset releases
    rst_n = 1'b1;
    push_items(8'hFE, 4);
    exp_done.push_back(16'd4);
    start_burst(8'hFE, 16'd4, 4'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_sent_start", {16'd0, sent_count}, 32'd0);
    expect_seq(5, 32'b01111, 32'b10000);
    chk("b2b_sent_final", {16'd0, sent_count}, 32'd4);
    chk("b2b_busy_end", {31'd0, busy}, 32'd0);

    // Two idle cycles between items
    push_items(8'h80, 3);
    exp_done.push_back(16'd3);
    start_burst(8'h80, 16'd3, 4'd2);
    expect_seq(8, 32'h49, 32'h80);
    chk("gap_sent_final", {16'd0, sent_count}, 32'd3);

    // Backpressure holds valid and data
    ready = 1'b0;
    push_items(8'h10, 2);
    exp_done.push_back(16'd2);
    start_burst(8'h10, 16'd2, 4'd0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, valid}, 32'd1);
      chk("bp_data", {24'd0, data}, 32'h10);
      chk("bp_known", {31'd0, $isunknown(data)}, 32'd0);
    end
    @(posedge clk);
    #1;
    ready = 1'b1;
    wait_done(20);
    chk("bp_sent_final", {16'd0, sent_count}, 32'd2);

    // Abort under backpressure on item 3
    push_items(8'h20, 3);
    exp_done.push_back(16'd3);
    start_burst(8'h20, 16'd10, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ready = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_bp_valid", {31'd0, valid}, 32'd1);
      chk("abort_bp_data", {24'd0, data}, 32'h22);
    end
    @(posedge clk); #1;
    ready = 1'b1;
    wait_done(20);
    chk("abort_bp_sent", {16'd0, sent_count}, 32'd3);
    repeat (3) begin
      @(negedge clk);
      chk("abort_bp_quiet", {31'd0, valid}, 32'd0);
    end

    // Abort during a gap
    push_items(8'h40, 1);
    exp_done.push_back(16'd1);
    start_burst(8'h40, 16'd5, 4'd3);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(5);
    chk("abort_gap_sent", {16'd0, sent_count}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("abort_gap_quiet", {31'd0, valid}, 32'd0);
    end

    // Zero-length burst
    exp_done.push_back(16'd0);
    start_burst(8'h55, 16'd0, 4'd0);
    @(negedge clk);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_valid", {31'd0, valid}, 32'd0);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("zero_done_pulse", {31'd0, done}, 32'd0);

    // Start while busy must be ignored
    push_items(8'h30, 3);
    exp_done.push_back(16'd3);
    start_burst(8'h30, 16'd3, 4'd1);
    @(posedge clk); #1;
    start_burst(8'hA0, 16'd5, 4'd0);
    wait_done(30);
    chk("busy_start_sent", {16'd0, sent_count}, 32'd3);

    // Reset mid-burst
    push_items(8'h60, 2);
    start_burst(8'h60, 16'd6, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_sent_two", {16'd0, sent_count}, 32'd2);
    ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_sent", {16'd0, sent_count}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_done", {31'd0, done}, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready = 1'b1;
    push_items(8'h70, 2);
    exp_done.push_back(16'd2);
    start_burst(8'h70, 16'd2, 4'd2);
    wait_done(30);
    chk("post_rst_sent", {16'd0, sent_count}, 32'd2);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_data_drained", exp_data.size(), 32'd0);
    chk("sb_done_drained", exp_done.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
